btsw_seq: RTL and testbench
===========================

Name: btsw_seq

Overview:
- Parametrised sequencing controller for a bank of NCH bootstrapped sampling switches that share one SAR converter.
- Per channel, in order: holds the switch clock low for a programmable precharge window so the boost capacitor charges, then drives a track pulse of programmable width, then a non-overlap gap, then a start-of-conversion handshake with the SAR core.
- Scans every enabled channel in ascending index order, either once or continuously.
- Sits between the ADC top-level control and the per-channel switch CK inputs.

Parameters:
- NCH, 4, number of sampling channels (2..16).
- CW, 4, width of the PRE/TRK/NOV cycle-count inputs.
- TOW, 8, width of the EOC timeout counter.
- TO_CYC, 200, number of CONV cycles before timeout (must be < 2^TOW).

Ports:
- CK  input  1  system clock, rising edge.
- RSTN  input  1  synchronous active-low reset.
- START  input  1  one-cycle scan request; honoured only in IDLE.
- CONT  input  1  continuous mode; sampled at every end-of-channel decision.
- CH_EN  input  NCH  channel enable mask; latched on accepted START.
- PRE_CYC  input  CW  precharge cycles; 0 is treated as 1.
- TRK_CYC  input  CW  track cycles; 0 is treated as 1.
- NOV_CYC  input  CW  non-overlap cycles; 0 skips the NOV state.
- EOC  input  1  end of conversion from the SAR core; level or pulse.
- SMP_CK  output  NCH  one-hot switch clock; high means track.
- SOC  output  1  one-cycle start-of-conversion pulse.
- CH_ID  output  clog2(NCH)  index of the active channel.
- BUSY  output  1  high whenever state is not IDLE.
- DONE  output  1  one-cycle pulse at the end of a single scan.
- ERR  output  1  sticky EOC-timeout flag.

Behaviour:
- Reset: RSTN low at an edge forces state IDLE, SMP_CK=0, SOC=0, CH_ID=0, BUSY=0, DONE=0, ERR=0, and clears all counters. Mid-operation reset takes effect at that same edge; no partial pulse continues afterwards.
- All outputs are registered.
- States: IDLE, PRE, TRK, NOV, CONV.
- IDLE:
  - START=1 with CH_EN≠0: latch CH_EN into EN_L, set CH_ID to the lowest set bit, clear ERR, go to PRE.
  - START with CH_EN=0: ignored, no flags change.
- PRE: SMP_CK=0 for max(PRE_CYC,1) cycles, then go to TRK.
- TRK: SMP_CK[CH_ID]=1, all other bits 0, for max(TRK_CYC,1) cycles. Then go to NOV, or to CONV if NOV_CYC=0.
- NOV: SMP_CK=0 for NOV_CYC cycles, then go to CONV.
- CONV:
  - SOC=1 in the first CONV cycle only.
  - EOC is ignored in that first cycle; it is recognised from the second CONV cycle onward.
  - EOC=1, or timeout counter reaching TO_CYC: end-of-channel decision. On timeout, ERR is set.
- End-of-channel decision:
  - Higher-index bit set in EN_L: CH_ID goes to that bit, go to PRE.
  - None set and CONT=1: CH_ID goes to the lowest set bit of EN_L, go to PRE.
  - None set and CONT=0: DONE=1 for one cycle, go to IDLE.
- Timing for START accepted at edge 0 with P=PRE_CYC, T=TRK_CYC, N=NOV_CYC:
  - SMP_CK high after edges P+1 … P+T.
  - SOC high after edge P+T+N+1.
- START while BUSY is ignored. CH_EN changes while BUSY have no effect.
- PRE_CYC, TRK_CYC and NOV_CYC are sampled at entry to each state, so changes apply from the next state entry.
- A single-channel mask with CONT=1 repeats PRE→TRK→(NOV)→CONV on that channel indefinitely.
- Clearing CONT mid-scan completes the current pass through the highest enabled channel, then pulses DONE.
- ERR remains set until the next accepted START or reset.
- SMP_CK is never multi-hot. SMP_CK is never high in the same cycle as SOC.
- CH_ID holds its last value in IDLE.

Test Plan:
- NCH=4, CH_EN=4'b1010, PRE=2, TRK=3, NOV=1, CONT=0, EOC 3 cycles after each SOC → SMP_CK[1] high for 3 cycles, then SMP_CK[3] high for 3 cycles; SOC after edge 7; one DONE pulse; BUSY low afterwards.
- PRE=0, TRK=0, NOV=0, CH_EN=4'b0001 → 1-cycle precharge, 1-cycle track, SOC in the cycle directly after track, no NOV cycle.
- CONT=1, CH_EN=4'b0110; clear CONT during channel 1's CONV → channel order 1,2,1,2,1,2; DONE fires after the last channel-2 conversion.
- EOC held low, TO_CYC=200 → ERR sets 200 cycles after SOC and the scan proceeds to the next channel. The next START clears ERR.
- Pull RSTN low during TRK, and START during BUSY → reset: all outputs 0 on the next cycle. START during BUSY: ignored, scan order unchanged.
- START with CH_EN=0 → BUSY stays 0, no SOC, no DONE.

Source files
------------

// File: rtl/btsw_seq.sv
// Sequencing controller for NCH bootstrapped sampling switches sharing one SAR core.
// Per enabled channel: precharge, track pulse, non-overlap gap, then SOC/EOC handshake.
module btsw_seq #(
    parameter int NCH    = 4,
    parameter int CW     = 4,
    parameter int TOW    = 8,
    parameter int TO_CYC = 200,
    localparam int IW    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           CK,
    input  logic           RSTN,
    input  logic           START,
    input  logic           CONT,
    input  logic [NCH-1:0] CH_EN,
    input  logic [CW-1:0]  PRE_CYC,
    input  logic [CW-1:0]  TRK_CYC,
    input  logic [CW-1:0]  NOV_CYC,
    input  logic           EOC,
    output logic [NCH-1:0] SMP_CK,
    output logic           SOC,
    output logic [IW-1:0]  CH_ID,
    output logic           BUSY,
    output logic           DONE,
    output logic           ERR
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_TRK,
        S_NOV,
        S_CONV
    } state_t;

    state_t          state_q, state_d;
    logic [NCH-1:0]  en_l_q, en_l_d;
    logic [IW-1:0]   ch_q, ch_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [TOW-1:0]  tmo_q, tmo_d;
    logic            err_q, err_d;
    logic [NCH-1:0]  smp_ck_q, smp_ck_d;
    logic            soc_q, soc_d;
    logic [IW-1:0]   ch_id_q, ch_id_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [CW-1:0]   pre_eff;
    logic [CW-1:0]   trk_eff;
    logic            hi_found;
    logic [IW-1:0]   hi_idx;
    logic            eoc_hit;
    logic            tmo_hit;

    function automatic logic [IW-1:0] lowest_set(input logic [NCH-1:0] m);
        logic [IW-1:0] r;
        r = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (m[i]) r = IW'(i);
        end
        return r;
    endfunction

    // Zero-length precharge and track windows collapse to a single cycle.
    assign pre_eff = (PRE_CYC == '0) ? CW'(1) : PRE_CYC;
    assign trk_eff = (TRK_CYC == '0) ? CW'(1) : TRK_CYC;

    assign eoc_hit = EOC && (tmo_q != '0);
    assign tmo_hit = (tmo_q == TOW'(TO_CYC));

    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (en_l_q[i] && (i > int'(ch_q))) begin
                hi_found = 1'b1;
                hi_idx   = IW'(i);
            end
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d = state_q;
        en_l_d  = en_l_q;
        ch_d    = ch_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (START && (CH_EN != '0)) begin
                    en_l_d  = CH_EN;
                    ch_d    = lowest_set(CH_EN);
                    err_d   = 1'b0;
                    cnt_d   = pre_eff;
                    state_d = S_PRE;
                end
            end
            S_PRE: begin
                if (cnt_q <= CW'(1)) begin
                    cnt_d   = trk_eff;
                    state_d = S_TRK;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_TRK: begin
                if (cnt_q <= CW'(1)) begin
                    if (NOV_CYC == '0) begin
                        tmo_d   = '0;
                        state_d = S_CONV;
                    end else begin
                        cnt_d   = NOV_CYC;
                        state_d = S_NOV;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_NOV: begin
                if (cnt_q <= CW'(1)) begin
                    tmo_d   = '0;
                    state_d = S_CONV;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_CONV: begin
                tmo_d = tmo_q + TOW'(1);
                if (eoc_hit || tmo_hit) begin
                    if (!eoc_hit) err_d = 1'b1;
                    if (hi_found) begin
                        ch_d    = hi_idx;
                        cnt_d   = pre_eff;
                        state_d = S_PRE;
                    end else if (CONT) begin
                        ch_d    = lowest_set(en_l_q);
                        cnt_d   = pre_eff;
                        state_d = S_PRE;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Switch/handshake outputs are registered decodes of the current state, one cycle behind it.
    always_comb begin
        smp_ck_d = (state_q == S_TRK) ? (NCH'(1) << ch_q) : '0;
        soc_d    = (state_q == S_CONV) && (tmo_q == '0);
        ch_id_d  = ch_q;
        busy_d   = (state_q != S_IDLE);
    end

    always_ff @(posedge CK) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (!RSTN) begin
            state_q  <= S_IDLE;
            en_l_q   <= '0;
            ch_q     <= '0;
            cnt_q    <= '0;
            tmo_q    <= '0;
            err_q    <= 1'b0;
            smp_ck_q <= '0;
            soc_q    <= 1'b0;
            ch_id_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            en_l_q   <= en_l_d;
            ch_q     <= ch_d;
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
            err_q    <= err_d;
            smp_ck_q <= smp_ck_d;
            soc_q    <= soc_d;
            ch_id_q  <= ch_id_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign SMP_CK = smp_ck_q;
    assign SOC    = soc_q;
    assign CH_ID  = ch_id_q;
    assign BUSY   = busy_q;
    assign DONE   = done_q;
    assign ERR    = err_q;

endmodule

// File: tb/tb_btsw_seq.sv
// Self-checking bench for btsw_seq: event scoreboard fed by a timing model of each scan,
// a vector table of scan configurations, and hand-written reset/timeout/ignored-START cases.
module tb_btsw_seq;

    localparam int NCH    = 4;
    localparam int CW     = 4;
    localparam int TOW    = 8;
    localparam int TO_CYC = 200;
    localparam int IW     = 2;

    localparam int EV_RISE = 0;
    localparam int EV_FALL = 1;
    localparam int EV_SOC  = 2;
    localparam int EV_DONE = 3;

    typedef struct {
        int kind;
        int ch;
        int cyc;
    } ev_t;

    typedef struct {
        logic [NCH-1:0] en;
        int             p;
        int             t;
        int             n;
        int             d;
        int             passes;
        bit             poke;
    } vec_t;

    logic           CK = 1'b0;
    logic           RSTN;
    logic           START;
    logic           CONT;
    logic [NCH-1:0] CH_EN;
    logic [CW-1:0]  PRE_CYC;
    logic [CW-1:0]  TRK_CYC;
    logic [CW-1:0]  NOV_CYC;
    logic           EOC;
    logic [NCH-1:0] SMP_CK;
    logic           SOC;
    logic [IW-1:0]  CH_ID;
    logic           BUSY;
    logic           DONE;
    logic           ERR;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   soc_cnt = 0;
    int   clear_at = 0;
    int   eoc_dly = 3;
    int   inv_viol = 0;
    int   err_rise_cyc = -1;
    bit   cont_cfg = 1'b0;
    bit   mon_en = 1'b1;
    logic [NCH-1:0] prev_smp = '0;
    logic prev_err = 1'b0;
    ev_t  sbq[$];
    vec_t vecs[6];

    btsw_seq #(
        .NCH    (NCH),
        .CW     (CW),
        .TOW    (TOW),
        .TO_CYC (TO_CYC)
    ) dut (
        .CK      (CK),
        .RSTN    (RSTN),
        .START   (START),
        .CONT    (CONT),
        .CH_EN   (CH_EN),
        .PRE_CYC (PRE_CYC),
        .TRK_CYC (TRK_CYC),
        .NOV_CYC (NOV_CYC),
        .EOC     (EOC),
        .SMP_CK  (SMP_CK),
        .SOC     (SOC),
        .CH_ID   (CH_ID),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .ERR     (ERR)
    );

    always #5 CK = ~CK;
    always @(posedge CK) cyc <= cyc + 1;

    // CONT drops on the SOC numbered clear_at, i.e. during the last pass's first conversion.
    assign CONT = cont_cfg && (soc_cnt < clear_at);

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int idx_of(input logic [NCH-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < NCH; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic sb_event(input int kind, input int ch, input int c);
        ev_t e;
        if (mon_en) begin
            if (sbq.size() == 0) begin
                check($sformatf("unexpected event kind %0d ch %0d at cycle", kind, ch), c, -1);
            end else begin
                e = sbq.pop_front();
                check("event kind", kind, e.kind);
                check("event channel", ch, e.ch);
                check("event cycle", c, e.cyc);
            end
        end
    endtask

    // Expected event stream of one scan whose START is sampled at edge start_c.
    task automatic push_scan(input logic [NCH-1:0] en, input int p, input int t, input int n,
                             input int d, input int passes, input int start_c);
        int pe, te, b, s;
        pe = (p == 0) ? 1 : p;
        te = (t == 0) ? 1 : t;
        b  = start_c;
        for (int ps = 0; ps < passes; ps++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                if (en[ch]) begin
                    sbq.push_back('{EV_RISE, ch, b + pe + 1});
                    sbq.push_back('{EV_FALL, ch, b + pe + te + 1});
                    s = b + pe + te + n + 1;
                    sbq.push_back('{EV_SOC, ch, s});
                    b = (d == 0) ? s + TO_CYC : s + d + 1;
                end
            end
        end
        sbq.push_back('{EV_DONE, 0, b});
    endtask

    always @(negedge CK) begin
        if (((SMP_CK & (SMP_CK - 1'b1)) != '0) || ((SMP_CK != '0) && SOC)) inv_viol++;
        if ((prev_smp != '0) && (SMP_CK != prev_smp)) sb_event(EV_FALL, idx_of(prev_smp), cyc);
        if ((SMP_CK != '0) && (SMP_CK != prev_smp)) sb_event(EV_RISE, idx_of(SMP_CK), cyc);
        if (SOC) sb_event(EV_SOC, int'(CH_ID), cyc);
        if (DONE) begin
            sb_event(EV_DONE, 0, cyc);
            done_cnt++;
        end
        if (ERR && !prev_err) err_rise_cyc = cyc;
        prev_smp = SMP_CK;
        prev_err = ERR;
    end

    // SAR core model: answers each SOC with a one-cycle EOC eoc_dly cycles later (0 = never).
    initial begin
        EOC = 1'b0;
        forever begin
            @(negedge CK);
            if (SOC && mon_en) begin
                soc_cnt++;
                if (eoc_dly > 0) begin
                    repeat (eoc_dly) @(posedge CK);
                    #1 EOC = 1'b1;
                    @(posedge CK);
                    #1 EOC = 1'b0;
                end
            end
        end
    end

    task automatic run_scan(input logic [NCH-1:0] en, input int p, input int t, input int n,
                            input int d, input int passes, input bit poke, output int start_c);
        int d0;
        @(posedge CK);
        #1;
        CH_EN    = en;
        PRE_CYC  = CW'(p);
        TRK_CYC  = CW'(t);
        NOV_CYC  = CW'(n);
        eoc_dly  = d;
        cont_cfg = (passes > 1);
        clear_at = soc_cnt + (passes - 1) * $countones(en) + 1;
        START    = 1'b1;
        start_c  = cyc + 1;
        push_scan(en, p, t, n, d, passes, start_c);
        d0 = done_cnt;
        @(posedge CK);
        #1 START = 1'b0;
        @(negedge CK);
        check("ERR cleared by accepted START", int'(ERR), 0);
        if (poke) begin
            repeat (3) @(posedge CK);
            #1;
            START = 1'b1;
            CH_EN = 4'b0001;
            @(posedge CK);
            #1;
            START = 1'b0;
            CH_EN = en;
        end
        for (int k = 0; k < 3000 && done_cnt == d0; k++) @(negedge CK);
        check("DONE pulses for scan", done_cnt - d0, 1);
        @(negedge CK);
        check("BUSY low after scan", int'(BUSY), 0);
        check("expected events left over", sbq.size(), 0);
        sbq.delete();
        cont_cfg = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got %0d cycles, expected completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int sc;
        int cnt;
        vecs[0] = '{4'b1010,  2,  3,  1, 3, 1, 1'b0};
        vecs[1] = '{4'b0001,  0,  0,  0, 2, 1, 1'b0};
        vecs[2] = '{4'b0110,  1,  2,  0, 1, 3, 1'b0};
        vecs[3] = '{4'b1111,  3,  1,  2, 1, 1, 1'b1};
        vecs[4] = '{4'b1000, 15, 15, 15, 5, 1, 1'b0};
        vecs[5] = '{4'b0101,  1,  1,  1, 4, 2, 1'b0};

        RSTN    = 1'b0;
        START   = 1'b0;
        CH_EN   = '0;
        PRE_CYC = '0;
        TRK_CYC = '0;
        NOV_CYC = '0;
        repeat (3) @(posedge CK);
        @(negedge CK);
        check("reset SMP_CK", int'(SMP_CK), 0);
        check("reset SOC", int'(SOC), 0);
        check("reset CH_ID", int'(CH_ID), 0);
        check("reset BUSY", int'(BUSY), 0);
        check("reset DONE", int'(DONE), 0);
        check("reset ERR", int'(ERR), 0);
        @(posedge CK);
        #1 RSTN = 1'b1;

        // EOC never arrives: each channel times out, ERR rises TO_CYC cycles after the first SOC.
        run_scan(4'b0011, 1, 1, 0, 0, 1, 1'b0, sc);
        check("ERR rise cycle on timeout", err_rise_cyc, sc + 1 + 1 + 0 + 1 + TO_CYC);
        check("ERR sticky after scan", int'(ERR), 1);

        for (int i = 0; i < 6; i++) begin
            run_scan(vecs[i].en, vecs[i].p, vecs[i].t, vecs[i].n, vecs[i].d,
                     vecs[i].passes, vecs[i].poke, sc);
            check($sformatf("ERR after vector %0d", i), int'(ERR), 0);
        end

        // Reset in the middle of a track pulse.
        @(posedge CK);
        #1;
        CH_EN   = 4'b0100;
        PRE_CYC = 4'd2;
        TRK_CYC = 4'd3;
        NOV_CYC = 4'd1;
        eoc_dly = 3;
        START   = 1'b1;
        push_scan(4'b0100, 2, 3, 1, 3, 1, cyc + 1);
        @(posedge CK);
        #1 START = 1'b0;
        for (int k = 0; k < 20 && SMP_CK == '0; k++) @(negedge CK);
        check("SMP_CK tracking before reset", int'(SMP_CK), 4);
        @(posedge CK);
        #1;
        mon_en = 1'b0;
        RSTN   = 1'b0;
        @(posedge CK);
        @(negedge CK);
        sbq.delete();
        check("mid-scan reset SMP_CK", int'(SMP_CK), 0);
        check("mid-scan reset SOC", int'(SOC), 0);
        check("mid-scan reset CH_ID", int'(CH_ID), 0);
        check("mid-scan reset BUSY", int'(BUSY), 0);
        check("mid-scan reset DONE", int'(DONE), 0);
        @(posedge CK);
        #1 RSTN = 1'b1;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge CK);
            if (BUSY || SMP_CK != '0 || SOC) cnt++;
        end
        check("activity after mid-scan reset", cnt, 0);
        mon_en = 1'b1;

        // START with an empty mask is ignored.
        @(posedge CK);
        #1;
        CH_EN = '0;
        START = 1'b1;
        @(posedge CK);
        #1 START = 1'b0;
        cnt = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge CK);
            if (BUSY || SOC || DONE) cnt++;
        end
        check("activity after START with empty mask", cnt, 0);

        check("SMP_CK multi-hot or overlapping SOC cycles", inv_viol, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
